// File: rtl/flash_boot_copier_pkg.sv
// rtl/flash_boot_copier_pkg.sv - shared state type, AXI constants and sizing helper for the boot copier
`ifndef TOP_DEFINES_VH
`define TOP_DEFINES_VH
`define AXI_ADDR_WIDTH 32
`define AXI_DATA_WIDTH 32
`define AXI_RESP_OKAY 2'b00
`define AXI_RESP_SLVERR 2'b10
`define BOOT_ARPROT 3'b100
`endif

package flash_boot_copier_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [1:0] RESP_OKAY   = `AXI_RESP_OKAY;
   localparam logic [2:0] ARPROT_BOOT = `BOOT_ARPROT;

   // Word counter must hold WORDS itself; keep at least one bit for WORDS == 0.
   function automatic int unsigned cnt_width(input int unsigned words);
      return (words < 1) ? 1 : $clog2(words + 1);
   endfunction

endpackage

// File: rtl/flash_boot_copier.sv
// rtl/flash_boot_copier.sv - AXI4-lite read master that copies flash words into imem at boot
// Holds the core in reset until every word has been copied with an OKAY response.
`ifndef TOP_DEFINES_VH
`define TOP_DEFINES_VH
`define AXI_ADDR_WIDTH 32
`define AXI_DATA_WIDTH 32
`define AXI_RESP_OKAY 2'b00
`define AXI_RESP_SLVERR 2'b10
`define BOOT_ARPROT 3'b100
`endif

module flash_boot_copier
   import flash_boot_copier_pkg::*;
#(
   parameter logic [31:0] SRC_BASE = 32'h0000_0000,
   parameter int unsigned DST_BASE = 0,
   parameter int unsigned WORDS    = 1024,
   parameter int unsigned IMEM_AW  = 16
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   output logic                       ARVALID,
   input  logic                       ARREADY,
   output logic [`AXI_ADDR_WIDTH-1:0] ARADDR,
   output logic [2:0]                 ARPROT,
   input  logic                       RVALID,
   output logic                       RREADY,
   input  logic [`AXI_DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]                 RRESP,
   output logic                       imem_we,
   output logic [IMEM_AW-1:0]         imem_addr,
   output logic [31:0]                imem_wdata,
   input  logic                       restart,
   output logic                       core_rst_n,
   output logic                       boot_done,
   output logic                       boot_err
);

   localparam int unsigned    CW   = cnt_width(WORDS);
   localparam int unsigned    AW   = `AXI_ADDR_WIDTH;
   localparam logic [CW-1:0]  LAST = CW'(WORDS);

   state_t              r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt;
   logic                w_capture;
   logic                r_arvalid, r_rready, r_imem_we;
   logic                r_core_rst_n, r_boot_done, r_boot_err;
   logic [AW-1:0]       r_araddr;
   logic [IMEM_AW-1:0]  r_imem_addr;
   logic [31:0]         r_imem_wdata;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE:  w_state_nxt = (WORDS == 0) ? ST_DONE : ST_ADDR;
         ST_ADDR:  if (r_arvalid && ARREADY) w_state_nxt = ST_DATA;
         ST_DATA: begin
            if (r_rready && RVALID) begin
               if (RRESP == RESP_OKAY) begin
                  w_state_nxt = ST_WRITE;
                  w_capture   = 1'b1;
               end else begin
                  w_state_nxt = ST_ERR;
               end
            end
         end
         ST_WRITE: begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = (w_cnt_nxt == LAST) ? ST_DONE : ST_ADDR;
         end
         ST_DONE, ST_ERR: begin
            if (restart) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with the state.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_imem_we    <= 1'b0;
         r_core_rst_n <= 1'b0;
         r_boot_done  <= 1'b0;
         r_boot_err   <= 1'b0;
         r_araddr     <= AW'(SRC_BASE);
         r_imem_addr  <= IMEM_AW'(DST_BASE);
         r_imem_wdata <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_arvalid    <= (w_state_nxt == ST_ADDR);
         r_rready     <= (w_state_nxt == ST_DATA);
         r_imem_we    <= (w_state_nxt == ST_WRITE);
         r_core_rst_n <= (w_state_nxt == ST_DONE);
         r_boot_done  <= (w_state_nxt == ST_DONE);
         r_boot_err   <= (w_state_nxt == ST_ERR);
         if (w_state_nxt == ST_ADDR)
            r_araddr <= AW'(SRC_BASE) + (AW'(w_cnt_nxt) << 2);
         if (w_state_nxt == ST_WRITE)
            r_imem_addr <= IMEM_AW'(DST_BASE) + IMEM_AW'(r_cnt);
         if (w_capture)
            r_imem_wdata <= RDATA[31:0];
      end
   end

   assign ARVALID    = r_arvalid;
   assign ARADDR     = r_araddr;
   assign ARPROT     = ARPROT_BOOT;
   assign RREADY     = r_rready;
   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign core_rst_n = r_core_rst_n;
   assign boot_done  = r_boot_done;
   assign boot_err   = r_boot_err;

endmodule

// File: tb/tb_flash_boot_copier.sv
// tb/tb_flash_boot_copier.sv - self-checking bench: flash slave model, imem model, scenario tasks
`ifndef TOP_DEFINES_VH
`define TOP_DEFINES_VH
`define AXI_ADDR_WIDTH 32
`define AXI_DATA_WIDTH 32
`define AXI_RESP_OKAY 2'b00
`define AXI_RESP_SLVERR 2'b10
`define BOOT_ARPROT 3'b100
`endif

module tb_flash_boot_copier;

   localparam logic [31:0] SRC = 32'h0000_1000;
   localparam int          DST = 8;
   localparam int          NW  = 4;
   localparam int          IAW = 6;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic            aresetn, rst0_n, restart;
   logic            arvalid, arready, rvalid, rready, imem_we, core_rst_n, boot_done, boot_err;
   logic [31:0]     araddr, rdata, imem_wdata;
   logic [2:0]      arprot;
   logic [1:0]      rresp;
   logic [IAW-1:0]  imem_addr;

   logic            z_arvalid, z_rready, z_imem_we, z_core_rst_n, z_boot_done, z_boot_err;
   logic            z_arready, z_rvalid, z_restart;
   logic [31:0]     z_araddr, z_rdata, z_imem_wdata;
   logic [2:0]      z_arprot;
   logic [1:0]      z_rresp;
   logic [IAW-1:0]  z_imem_addr;

   flash_boot_copier #(.SRC_BASE(SRC), .DST_BASE(DST), .WORDS(NW), .IMEM_AW(IAW)) dut (
      .ACLK(aclk), .ARESETn(aresetn), .ARVALID(arvalid), .ARREADY(arready), .ARADDR(araddr),
      .ARPROT(arprot), .RVALID(rvalid), .RREADY(rready), .RDATA(rdata), .RRESP(rresp),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .restart(restart),
      .core_rst_n(core_rst_n), .boot_done(boot_done), .boot_err(boot_err));

   flash_boot_copier #(.SRC_BASE(SRC), .DST_BASE(DST), .WORDS(0), .IMEM_AW(IAW)) dut0 (
      .ACLK(aclk), .ARESETn(rst0_n), .ARVALID(z_arvalid), .ARREADY(z_arready), .ARADDR(z_araddr),
      .ARPROT(z_arprot), .RVALID(z_rvalid), .RREADY(z_rready), .RDATA(z_rdata), .RRESP(z_rresp),
      .imem_we(z_imem_we), .imem_addr(z_imem_addr), .imem_wdata(z_imem_wdata), .restart(z_restart),
      .core_rst_n(z_core_rst_n), .boot_done(z_boot_done), .boot_err(z_boot_err));

   int errors = 0;
   int checks = 0;

   // flash contents and slave behaviour knobs
   logic [31:0] mem [0:NW-1];
   int          err_word    = -1;
   int          ar_delay_cfg = -1;

   // observations collected by the monitor
   logic [31:0] imem_model [0:(1<<IAW)-1];
   logic [31:0] ar_addrs[$];
   int          ar_waits[$];
   int          we_cnt, overlap_err, stab_err, arv_in_err, z_arv_cnt, cur_wait;
   bit          prev_ar_wait;
   logic [31:0] prev_addr;

   // flash slave: decisions made on the falling edge, handshakes land on the next rising edge
   initial begin : slave
      bit          ar_hs, r_hs, pending, ar_started;
      int          ar_wait_left, r_wait, pidx;
      logic [31:0] ar_addr_lat;
      ar_hs = 0; r_hs = 0; pending = 0; ar_started = 0; ar_wait_left = 0; r_wait = 0; pidx = 0;
      ar_addr_lat = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            arready = 1'b0; rvalid = 1'b0; pending = 0; ar_hs = 0; r_hs = 0; ar_started = 0;
         end else begin
            if (ar_hs) begin
               pending = 1;
               pidx    = int'((ar_addr_lat - SRC) >> 2);
               r_wait  = $urandom_range(0, 2);
            end
            if (r_hs) begin
               rvalid  = 1'b0;
               pending = 0;
            end
            ar_hs = 0;
            if (arvalid && !pending) begin
               if (!ar_started) begin
                  ar_started   = 1;
                  ar_wait_left = (ar_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ar_delay_cfg;
               end
               if (ar_wait_left > 0) begin
                  arready = 1'b0;
                  ar_wait_left--;
               end else begin
                  arready     = 1'b1;
                  ar_hs       = 1;
                  ar_addr_lat = araddr;
                  ar_started  = 0;
               end
            end else begin
               arready = 1'b0;
            end
            if (pending && !rvalid) begin
               if (r_wait > 0) r_wait--;
               else begin
                  rvalid = 1'b1;
                  rdata  = (pidx >= 0 && pidx < NW) ? mem[pidx] : 32'hDEAD_BEEF;
                  rresp  = (pidx == err_word) ? `AXI_RESP_SLVERR : `AXI_RESP_OKAY;
               end
            end
            r_hs = rvalid && rready;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge aclk);
         #1;
         if (z_arvalid) z_arv_cnt++;
         if (aresetn) begin
            if (imem_we) begin
               imem_model[imem_addr] = imem_wdata;
               we_cnt++;
            end
            if (arvalid && rready) overlap_err++;
            if (arvalid && prev_ar_wait && araddr !== prev_addr) stab_err++;
            if (arvalid && !arready) cur_wait++;
            if (arvalid && arready) begin
               ar_addrs.push_back(araddr);
               ar_waits.push_back(cur_wait);
               cur_wait = 0;
            end
            if (arvalid && boot_err) arv_in_err++;
            prev_ar_wait = arvalid && !arready;
            prev_addr    = araddr;
         end else begin
            prev_ar_wait = 0;
            cur_wait     = 0;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_stats();
      for (int i = 0; i < (1 << IAW); i++) imem_model[i] = '0;
      ar_addrs.delete();
      ar_waits.delete();
      we_cnt = 0; overlap_err = 0; stab_err = 0; arv_in_err = 0; cur_wait = 0; prev_ar_wait = 0;
   endtask

   task automatic pulse_restart();
      @(negedge aclk); restart = 1'b1;
      @(negedge aclk); restart = 1'b0;
      #2;
   endtask

   task automatic wait_end(input string name, input int limit);
      bit ok = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge aclk); #2;
         if (boot_done || boot_err) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL %s: no boot_done/boot_err within %0d cycles", name, limit); end
   endtask

   task automatic check_copy(input string name, input int n_ok);
      checks++;
      if (we_cnt !== n_ok) begin errors++; $display("FAIL %s we_count: got %0d want %0d", name, we_cnt, n_ok); end
      for (int i = 0; i < n_ok; i++) begin
         checks++;
         if (imem_model[DST + i] !== mem[i]) begin
            errors++;
            $display("FAIL %s imem[%0d]: got %h want %h", name, DST + i, imem_model[DST + i], mem[i]);
         end
      end
      checks++;
      if (overlap_err != 0 || stab_err != 0) begin
         errors++;
         $display("FAIL %s protocol: overlap=%0d unstable=%0d want 0/0", name, overlap_err, stab_err);
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if ({arvalid, rready, imem_we, core_rst_n, boot_done, boot_err} !== 6'b0) begin
         errors++;
         $display("FAIL %s ctrl: got %b want 000000", name,
                  {arvalid, rready, imem_we, core_rst_n, boot_done, boot_err});
      end
      checks++;
      if (araddr !== SRC || imem_addr !== IAW'(DST) || imem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL %s regs: araddr=%h imem_addr=%0d wdata=%h want %h %0d 0", name, araddr,
                  imem_addr, imem_wdata, SRC, DST);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0; rst0_n = 1'b0; restart = 1'b0;
      z_arready = 1'b0; z_rvalid = 1'b0; z_rdata = '0; z_rresp = 2'b00; z_restart = 1'b0;
      repeat (3) @(negedge aclk);
      #2;
      check_reset_values("reset");
      checks++;
      if (arprot !== 3'b100) begin errors++; $display("FAIL reset arprot: got %b want 100", arprot); end
      checks++;
      if (z_boot_done !== 1'b0 || z_core_rst_n !== 1'b0) begin
         errors++; $display("FAIL reset words0: done=%b core_rst_n=%b want 0 0", z_boot_done, z_core_rst_n);
      end
   endtask

   task automatic test_copy();
      for (int i = 0; i < NW; i++) mem[i] = 32'h1111_1111 * (i + 1);
      err_word = -1; ar_delay_cfg = -1;
      clear_stats();
      @(negedge aclk); aresetn = 1'b1;
      wait_end("copy", 400);
      check_copy("copy", NW);
      checks++;
      if ({boot_done, core_rst_n, boot_err} !== 3'b110) begin
         errors++; $display("FAIL copy status: done/crst/err got %b want 110", {boot_done, core_rst_n, boot_err});
      end
      checks++;
      if (ar_addrs.size() != NW) begin
         errors++; $display("FAIL copy ar_count: got %0d want %0d", ar_addrs.size(), NW);
      end else begin
         for (int i = 0; i < NW; i++) begin
            checks++;
            if (ar_addrs[i] !== SRC + 32'(4 * i)) begin
               errors++; $display("FAIL copy araddr[%0d]: got %h want %h", i, ar_addrs[i], SRC + 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_arready_hold();
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      ar_delay_cfg = 5;
      clear_stats();
      pulse_restart();
      wait_end("ar_hold", 600);
      ar_delay_cfg = -1;
      check_copy("ar_hold", NW);
      checks++;
      if (ar_waits.size() != NW) begin
         errors++; $display("FAIL ar_hold ar_count: got %0d want %0d", ar_waits.size(), NW);
      end
      foreach (ar_waits[i]) begin
         checks++;
         if (ar_waits[i] != 5) begin
            errors++; $display("FAIL ar_hold wait[%0d]: got %0d cycles want 5", i, ar_waits[i]);
         end
      end
   endtask

   task automatic test_error();
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      err_word = 2;
      clear_stats();
      pulse_restart();
      wait_end("error", 400);
      repeat (20) @(negedge aclk);
      #2;
      err_word = -1;
      check_copy("error", 2);
      checks++;
      if ({boot_err, boot_done, core_rst_n} !== 3'b100) begin
         errors++; $display("FAIL error status: err/done/crst got %b want 100", {boot_err, boot_done, core_rst_n});
      end
      checks++;
      if (arv_in_err != 0) begin
         errors++; $display("FAIL error arvalid_after: got %0d cycles want 0", arv_in_err);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      clear_stats();
      pulse_restart();
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge aclk); #2;
         seen = (we_cnt >= 1);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL reset_mid: first word never written"); end
      @(negedge aclk); #3;
      aresetn = 1'b0;
      #1;
      check_reset_values("reset_mid");
      repeat (2) @(negedge aclk);
      clear_stats();
      aresetn = 1'b1;
      wait_end("reset_mid", 400);
      check_copy("reset_mid", NW);
      checks++;
      if (ar_addrs.size() == 0 || ar_addrs[0] !== SRC) begin
         errors++; $display("FAIL reset_mid first_araddr: got %h want %h",
                            (ar_addrs.size() == 0) ? 32'hx : ar_addrs[0], SRC);
      end
   endtask

   task automatic test_restart();
      bit in_data = 0;
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      clear_stats();
      pulse_restart();
      checks++;
      if (core_rst_n !== 1'b0 || boot_done !== 1'b0) begin
         errors++; $display("FAIL restart clear: crst=%b done=%b want 0 0", core_rst_n, boot_done);
      end
      for (int i = 0; i < 50 && !in_data; i++) begin
         @(negedge aclk); #2;
         in_data = rready;
      end
      checks++;
      if (!in_data) begin errors++; $display("FAIL restart: never reached DATA"); end
      restart = 1'b1;
      @(negedge aclk); restart = 1'b0;
      wait_end("restart", 400);
      check_copy("restart", NW);
      checks++;
      if ({boot_done, core_rst_n, boot_err} !== 3'b110) begin
         errors++; $display("FAIL restart status: done/crst/err got %b want 110", {boot_done, core_rst_n, boot_err});
      end
   endtask

   task automatic test_words_zero();
      z_arv_cnt = 0;
      @(negedge aclk); rst0_n = 1'b1;
      repeat (2) @(posedge aclk);
      #2;
      checks++;
      if (z_boot_done !== 1'b1 || z_core_rst_n !== 1'b1) begin
         errors++; $display("FAIL words0 done: done=%b crst=%b want 1 1", z_boot_done, z_core_rst_n);
      end
      repeat (10) @(negedge aclk);
      #2;
      checks++;
      if (z_arv_cnt != 0 || z_boot_err !== 1'b0) begin
         errors++; $display("FAIL words0 bus: arvalid cycles=%0d err=%b want 0 0", z_arv_cnt, z_boot_err);
      end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_arready_hold();
      test_error();
      test_reset_mid();
      test_restart();
      test_words_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
